signed_divider: RTL and testbench

Sequential sign-magnitude restoring divider and the inverse companion of the team's 8x8 sign-magnitude multiplier. It accepts a product-format operand (14-bit magnitude plus separate sign) as dividend and an 8-bit sign-magnitude divisor. It produces a 14-bit quotient magnitude, a 7-bit remainder magnitude, and sign and zero flags in the same format as the multiplier's outputs. It computes one quotient bit per clock and sits beside the multiplier in the datapath.

---
 rtl/signed_divider.sv | 165 ++++++++++++++++
 tb/tb_signed_divider.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
//------------------------------------------------------------------------------
// Module   : signed_divider
// Brief    : Sequential sign-magnitude restoring divider, one quotient bit per
//            clock; companion of the 8x8 sign-magnitude multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module signed_divider #(
    parameter int DVD_W = 14,
    parameter int DVS_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dividend_sign,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-2:0] remainder,
    output logic             sign,
    output logic             zflag,
    output logic             div_by_zero
);

    localparam int MAG_W = DVS_W - 1;
    localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] prem_q, prem_d;
    logic [MAG_W-1:0] dvs_q, dvs_d;
    logic             dvd_sign_q, dvd_sign_d;
    logic             dvs_sign_q, dvs_sign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [MAG_W-1:0] rem_q, rem_d;
    logic             sign_q, sign_d;
    logic             zflag_q, zflag_d;
    logic             dbz_q, dbz_d;

    // One restoring step: {prem, dvd} shifted left, quotient bit enters dvd LSB.
    // A set prem MSB means the shifted value overflowed and is surely >= divisor.
    logic [DVS_W-1:0] w_shift;
    logic             w_ge;
    logic [DVS_W-1:0] w_prem_nxt;
    logic [DVD_W-1:0] w_dvd_nxt;
    logic             w_quo_zero;

    always_comb begin
        w_shift    = {prem_q[DVS_W-2:0], dvd_q[DVD_W-1]};
        w_ge       = prem_q[DVS_W-1] | (w_shift >= {1'b0, dvs_q});
        w_prem_nxt = w_ge ? (w_shift - {1'b0, dvs_q}) : w_shift;
        w_dvd_nxt  = {dvd_q[DVD_W-2:0], w_ge};
        w_quo_zero = (w_dvd_nxt == '0);
    end

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        prem_d     = prem_q;
        dvs_d      = dvs_q;
        dvd_sign_d = dvd_sign_q;
        dvs_sign_d = dvs_sign_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        sign_d     = sign_q;
        zflag_d    = zflag_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d      = dividend;
                    dvd_sign_d = dividend_sign;
                    dvs_sign_d = divisor[DVS_W-1];
                    dvs_d      = divisor[MAG_W-1:0];
                    prem_d     = '0;
                    cnt_d      = C_LAST_CNT;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = '0;
                    sign_d  = 1'b0;
                    zflag_d = 1'b0;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dvd_d  = w_dvd_nxt;
                    prem_d = w_prem_nxt;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_d   = w_dvd_nxt;
                        rem_d   = w_prem_nxt[MAG_W-1:0];
                        sign_d  = (dvd_sign_q ^ dvs_sign_q) & ~w_quo_zero;
                        zflag_d = w_quo_zero;
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            prem_q     <= '0;
            dvs_q      <= '0;
            dvd_sign_q <= 1'b0;
            dvs_sign_q <= 1'b0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            sign_q     <= 1'b0;
            zflag_q    <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            prem_q     <= prem_d;
            dvs_q      <= dvs_d;
            dvd_sign_q <= dvd_sign_d;
            dvs_sign_q <= dvs_sign_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            sign_q     <= sign_d;
            zflag_q    <= zflag_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign sign        = sign_q;
    assign zflag       = zflag_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_signed_divider.sv
//------------------------------------------------------------------------------
// Module   : tb_signed_divider
// Brief    : Randomised scoreboard bench for signed_divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_signed_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        dividend_sign;
    logic [13:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [13:0] quotient;
    logic [6:0]  remainder;
    logic        sign;
    logic        zflag;
    logic        div_by_zero;

    signed_divider #(.DVD_W(14), .DVS_W(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .dividend_sign (dividend_sign),
        .dividend      (dividend),
        .divisor       (divisor),
        .busy          (busy),
        .done          (done),
        .quotient      (quotient),
        .remainder     (remainder),
        .sign          (sign),
        .zflag         (zflag),
        .div_by_zero   (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        int dvd;
        int mag;
        int q;
        int r;
        int s;
        int z;
        int dbz;
        int lat;
        int issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   in_flight = 1'b0;
    bit   busy_gap = 1'b0;
    bit   prev_done = 1'b0;
    bit   done_seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: plain integer division on magnitudes. Latency counts edges
    // after the start edge until done is visible (done in the 15th cycle
    // after start normally, the 2nd for a zero divisor).
    function automatic exp_t ref_model(input int dvd, input bit sg, input logic [7:0] dv,
                                       input int issue_cyc);
        exp_t e;
        e.dvd   = dvd;
        e.mag   = int'(dv & 8'h7F);
        e.issue = issue_cyc;
        if (e.mag == 0) begin
            e.q = 16383; e.r = 0; e.s = 0; e.z = 0; e.dbz = 1; e.lat = 1;
        end else begin
            e.q   = dvd / e.mag;
            e.r   = dvd % e.mag;
            e.z   = (e.q == 0) ? 1 : 0;
            e.s   = (e.q == 0) ? 0 : int'(sg ^ dv[7]);
            e.dbz = 0;
            e.lat = 14;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT announces a result.
    always @(negedge clock) begin
        if (reset_n) begin
            if (in_flight && !done && !busy) busy_gap = 1'b1;
            if (done) begin
                done_seen = 1'b1;
                chk("done_one_cycle", longint'(prev_done), 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    mon_e = sb.pop_front();
                    chk("quotient", quotient, mon_e.q);
                    chk("remainder", remainder, mon_e.r);
                    chk("sign", sign, mon_e.s);
                    chk("zflag", zflag, mon_e.z);
                    chk("div_by_zero", div_by_zero, mon_e.dbz);
                    chk("latency", cyc - mon_e.issue, mon_e.lat);
                    chk("busy_at_done", busy, 1);
                    chk("busy_held", longint'(busy_gap), 0);
                    if (mon_e.dbz == 0) begin
                        chk("invariant", longint'(quotient) * mon_e.mag + remainder, mon_e.dvd);
                        chk("rem_lt_div", (int'(remainder) < mon_e.mag) ? 1 : 0, 1);
                    end
                end
                in_flight = 1'b0;
                busy_gap  = 1'b0;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic issue(input int dvd, input bit sg, input logic [7:0] dv);
        @(negedge clock);
        dividend      = 14'(dvd);
        dividend_sign = sg;
        divisor       = dv;
        start         = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        sb.push_back(ref_model(dvd, sg, dv, cyc));
        in_flight = 1'b1;
        dividend      = 14'($urandom);
        dividend_sign = 1'($urandom);
        divisor       = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (in_flight && n < 40) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (in_flight) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done within %0d cycles expected done", n);
            sb.delete();
            in_flight = 1'b0;
        end
    endtask

    task automatic run(input int dvd, input bit sg, input logic [7:0] dv);
        issue(dvd, sg, dv);
        wait_done();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_quotient"}, quotient, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_sign"}, sign, 0);
        chk({tag, "_zflag"}, zflag, 0);
        chk({tag, "_dbz"}, div_by_zero, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int dvd;
        logic [7:0] dv;
        reset_n       = 1'b0;
        start         = 1'b0;
        dividend_sign = 1'b0;
        dividend      = '0;
        divisor       = '0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run(30, 1'b0, 8'h03);
        run(31, 1'b0, 8'h83);
        run(5, 1'b1, 8'h0A);
        run(16383, 1'b0, 8'h01);
        run(16383, 1'b0, 8'h7F);
        run(100, 1'b0, 8'h80);
        run(0, 1'b1, 8'h85);

        // Start while busy must be ignored.
        issue(100, 1'b0, 8'h07);
        repeat (4) @(negedge clock);
        dividend = 14'd999; divisor = 8'h02; dividend_sign = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();

        // Asynchronous abort mid-operation.
        issue(50, 1'b1, 8'h03);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        sb.delete();
        in_flight = 1'b0;
        done_seen = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("abort_no_done", longint'(done_seen), 0);
        run(50, 1'b1, 8'h03);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       dvd = 16383;
                1:       dvd = 0;
                default: dvd = int'($urandom_range(0, 16383));
            endcase
            dv = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dv[6:0] = 7'd0;
            run(dvd, 1'($urandom), dv);
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
